// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing generator (640x480@60 by default).
// Produces the pixel coordinates, active-low sync pulses, the visible-area
// flag, a once-per-frame tick and a wrapping horizontal scroll offset.
// Optional feature macro: VGA_SCROLL_EN builds the per-frame scroll
// accumulator; without it x_offset is tied to 0 and pause/scroll_speed
// are ignored.
module vga_scan_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCROLL_WRAP = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic [2:0] scroll_speed,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       display_on,
  output logic       frame_tick,
  output logic [9:0] x_offset
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_LIMIT  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_LIMIT  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       display_next;
  logic       tick_next;

  // Next raster position, and the decodes of that position so the output
  // registers line up with the coordinates they describe.
  always_comb begin
    x_next = pix_x + 10'd1;
    y_next = pix_y;
    if (pix_x == H_LAST) begin
      x_next = '0;
      y_next = (pix_y == V_LAST) ? '0 : (pix_y + 10'd1);
    end
    hsync_next   = !((x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST));
    vsync_next   = !((y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST));
    display_next = (x_next < H_VIS_LIMIT) && (y_next < V_VIS_LIMIT);
    tick_next    = (x_next == '0) && (y_next == V_VIS_LIMIT);
  end

  // Raster counters and registered timing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x      <= '0;
      pix_y      <= '0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      display_on <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      pix_x      <= x_next;
      pix_y      <= y_next;
      hsync_n    <= hsync_next;
      vsync_n    <= vsync_next;
      display_on <= display_next;
      frame_tick <= tick_next;
    end
  end

`ifdef VGA_SCROLL_EN
  localparam logic [10:0] WRAP_LIMIT = 11'(SCROLL_WRAP);

  logic [10:0] scroll_sum;
  logic [9:0]  scroll_wrapped;

  // Offset plus speed in 11 bits, folded back below the wrap modulus.
  always_comb begin
    scroll_sum     = {1'b0, x_offset} + {8'b0, scroll_speed};
    scroll_wrapped = scroll_sum[9:0];
    if (scroll_sum >= WRAP_LIMIT) begin
      scroll_wrapped = 10'(scroll_sum - WRAP_LIMIT);
    end
  end

  // Scroll offset advances once per frame, at the end of the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_offset <= '0;
    end else if (frame_tick && !pause) begin
      x_offset <= scroll_wrapped;
    end
  end
`else
  logic unused_scroll;

  assign x_offset      = '0;
  assign unused_scroll = ^{pause, scroll_speed, 11'(SCROLL_WRAP)};
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scoreboard bench for vga_scan_gen using a shrunken raster
// so that many frames fit in a short run. Follows VGA_SCROLL_EN the same way
// the design does.
module tb_vga_scan_gen;

  localparam int HV = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VV = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int WRAP = 20;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam logic [33:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] scroll_speed = 3'd0;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       hsync_n;
  logic       vsync_n;
  logic       display_on;
  logic       frame_tick;
  logic [9:0] x_offset;
  logic [33:0] dut_vec;

  int n_checks = 0;
  int n_pass = 0;
  int m_x = 0;
  int m_y = 0;
  int m_off = 0;
  logic [33:0] exp_q[$];

  // Pixel clock.
  always #5 clk = ~clk;

  assign dut_vec = {pix_x, pix_y, hsync_n, vsync_n, display_on, frame_tick, x_offset};

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCROLL_WRAP(WRAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pause(pause),
    .scroll_speed(scroll_speed),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n),
    .display_on(display_on),
    .frame_tick(frame_tick),
    .x_offset(x_offset)
  );

  // Expected output vector for a raster position and scroll offset.
  function automatic logic [33:0] expVec(input int x, input int y, input int off);
    logic hs, vs, de, tk;
    hs = !(x >= HV + HF && x < HV + HF + HS);
    vs = !(y >= VV + VF && y < VV + VF + VS);
    de = (x < HV) && (y < VV);
    tk = (x == 0) && (y == VV);
    return {10'(x), 10'(y), hs, vs, de, tk, 10'(off)};
  endfunction

  task automatic checkOutput(input string tag, input logic [33:0] got, input logic [33:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at model (%0d,%0d) off %0d: got %h expected %h (x,y,hs,vs,de,tick,off)",
               tag, m_x, m_y, m_off, got, want);
    end
  endtask

  // Advance the reference one clock per cycle, queue its prediction, then
  // compare against the DUT just after the edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (m_x == 0 && m_y == VV && !pause) begin
`ifdef VGA_SCROLL_EN
        m_off = (m_off + int'(scroll_speed)) % WRAP;
`endif
      end
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y + 1) % VT;
      end else begin
        m_x = m_x + 1;
      end
      exp_q.push_back(expVec(m_x, m_y, m_off));
      @(posedge clk);
      #1;
      checkOutput("raster", dut_vec, exp_q.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", dut_vec, RESET_VEC);
    rst_n = 1'b1;
    #1;
    checkOutput("release", dut_vec, RESET_VEC);
    m_x = 0;
    m_y = 0;
    m_off = 0;

    // Steady scrolling at top speed, wraps the offset past the modulus.
    scroll_speed = 3'd7;
    pause = 1'b0;
    applyStimulus(3 * FRAME);

    // Paused for one tick.
    pause = 1'b1;
    applyStimulus(FRAME);

    // Speed changed mid-frame: only the value at the tick counts.
    pause = 1'b0;
    scroll_speed = 3'd5;
    applyStimulus(2 * HT);
    scroll_speed = 3'd2;
    applyStimulus(FRAME);

    // Random speed/pause changes at random points in the frame.
    for (int k = 0; k < 6; k++) begin
      scroll_speed = 3'($urandom_range(0, 7));
      pause = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(50, 400));
    end

    // Walk to a mid-frame position, then pulse reset between clock edges.
    pause = 1'b0;
    scroll_speed = 3'd7;
    for (int k = 0; k < FRAME && !(m_x == 12 && m_y == 5); k++) begin
      applyStimulus(1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", dut_vec, RESET_VEC);
    m_x = 0;
    m_y = 0;
    m_off = 0;
    @(negedge clk);
    checkOutput("rst_hold", dut_vec, RESET_VEC);
    rst_n = 1'b1;
    applyStimulus(2 * FRAME + HT);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
